// File: rtl/decode_pipe_reg_1_if.sv
// ----------------------------------------------------------------------------
// decode_pipe_reg_1_if
// Ready/valid bundle carrying one packed decoded-instruction payload.
//   valid   : producer has a payload this cycle
//   ready   : consumer can take the payload this cycle
//   payload : packed decode bundle (PW bits)
// Modports:
//   master : producer side (drives valid/payload, observes ready)
//   slave  : consumer side (observes valid/payload, drives ready)
// ----------------------------------------------------------------------------
interface decode_pipe_reg_1_if #(
    parameter int PW = 179
);
    logic          valid;
    logic          ready;
    logic [PW-1:0] payload;

    modport master (
        output valid,
        output payload,
        input  ready
    );

    modport slave (
        input  valid,
        input  payload,
        output ready
    );
endinterface

// File: rtl/decode_pipe_reg_1.sv
// ----------------------------------------------------------------------------
// decode_pipe_reg_1
// Two-entry elastic buffer between decode stage 1 and decode stage 2 /
// operand fetch. Registers the full decoded-instruction payload and breaks
// the combinational ready path: s1.ready depends only on the held count.
//
// Ports:
//   clk    : clock, all state updates on rising edge
//   reset  : asynchronous active-low reset
//   flush  : drop all held entries and the instruction offered this cycle
//   s1     : upstream bundle (slave)  - valid/payload in, ready out
//   s2     : downstream bundle (master) - valid/payload out, ready in
//   count  : number of held entries, 0..2
//
// Payload packing, MSB first:
//   size[3], set_d_flag, clear_d_flag, op0[3], op1[3], op0_reg[3], op1_reg[3],
//   modrm[8], sib[8], imm[48], disp[32], alu_op[4], flag_0[3], flag_1[3],
//   stack_op[2], seg_override[3], seg_override_valid, movs, pc[IADDRW],
//   branch_taken, opcode[16]
// The buffer never looks inside the payload; it is carried bit-exact.
// ----------------------------------------------------------------------------
module decode_pipe_reg_1 #(
    parameter int IADDRW = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    decode_pipe_reg_1_if.slave         s1,
    decode_pipe_reg_1_if.master        s2,
    output logic [1:0]                 count
);

    // Payload width follows from the packing order and tracks IADDRW only.
    localparam int PW = 147 + IADDRW;

    logic [PW-1:0] entry_q [2];
    logic [PW-1:0] entry_d [2];
    logic          rd_ptr_q, rd_ptr_d;
    logic          wr_ptr_q, wr_ptr_d;
    logic [1:0]    count_q,  count_d;

    logic          push;
    logic          pop;
    logic          s1_ready;
    logic          s2_valid;

    // Handshake outputs come straight from the count register, so there is
    // no path from s2.ready to s1.ready.
    assign s1_ready   = (count_q != 2'd2);
    assign s2_valid   = (count_q != 2'd0);
    assign s1.ready   = s1_ready;
    assign s2.valid   = s2_valid;
    assign s2.payload = entry_q[rd_ptr_q];
    assign count      = count_q;

    always_comb begin
        push       = s1.valid & s1_ready & ~flush;
        pop        = s2_valid & s2.ready & ~flush;

        entry_d[0] = entry_q[0];
        entry_d[1] = entry_q[1];
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;

        if (flush) begin
            // Flush wins over any same-cycle push or pop; the offered
            // instruction is squashed and both pointers return home.
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push) begin
                entry_d[wr_ptr_q] = s1.payload;
                wr_ptr_d          = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // Entries are functionally don't-care after reset; clearing them
            // keeps X out of s2.payload in simulation.
            entry_q[0] <= '0;
            entry_q[1] <= '0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
        end else begin
            entry_q[0] <= entry_d[0];
            entry_q[1] <= entry_d[1];
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

endmodule
